hazard_stall_unit: RTL and testbench

Stall and flush controller for the five-stage pipeline. It drives the write-enables consumed by the IF/ID pipeline register and the PC (PCWrite, IF_ID_Write, IF_ID_Flush) and the ID/EX bubble insert. It detects load-use and branch-operand hazards, holds the front end for the multi-cycle multiplier, and keeps a saturating count of stalled cycles for performance debug.

---
 rtl/hazard_stall_unit_if.sv | 33 +++
 rtl/hazard_stall_unit.sv | 80 ++++++++
 tb/tb_hazard_stall_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-control bundle between the hazard/stall unit and the pipeline datapath.
// The datapath side is the master: it drives the decode fields and consumes the enables.
interface hazard_stall_unit_if;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic        ID_UsesRt;
    logic        ID_IsBranch;
    logic        ID_BranchTaken;
    logic        ID_IsMul;
    logic        EX_MemRead;
    logic        EX_RegWrite;
    logic [4:0]  EX_Rd;
    logic        MEM_MemRead;
    logic [4:0]  MEM_Rd;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        IF_ID_Flush;
    logic        ID_EX_Bubble;
    logic        MulBusy;
    logic [15:0] StallCycles;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, ID_IsBranch, ID_BranchTaken, ID_IsMul,
               EX_MemRead, EX_RegWrite, EX_Rd, MEM_MemRead, MEM_Rd,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulBusy, StallCycles
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, ID_IsBranch, ID_BranchTaken, ID_IsMul,
               EX_MemRead, EX_RegWrite, EX_Rd, MEM_MemRead, MEM_Rd,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulBusy, StallCycles
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller: load-use and ID-branch hazards, multi-cycle multiply hold,
// and a saturating stalled-cycle counter.
module hazard_stall_unit #(
    parameter int MUL_LAT = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    hazard_stall_unit_if.slave hs
);
    typedef enum logic {RUN, BUSY} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic        mul_busy;
    logic [15:0] stall_cycles;

    logic rs_ex, rt_ex, rs_mem, rt_mem;
    logic lu, br, hz, stall;

    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src == dst) && (dst != 5'd0);
    endfunction

    always_comb begin
        rs_ex  = reg_match(hs.ID_Rs, hs.EX_Rd);
        rt_ex  = hs.ID_UsesRt && reg_match(hs.ID_Rt, hs.EX_Rd);
        rs_mem = reg_match(hs.ID_Rs, hs.MEM_Rd);
        rt_mem = hs.ID_UsesRt && reg_match(hs.ID_Rt, hs.MEM_Rd);
        lu     = hs.EX_MemRead && (rs_ex || rt_ex);
        br     = hs.ID_IsBranch &&
                 ((hs.EX_RegWrite && (rs_ex || rt_ex)) ||
                  (hs.MEM_MemRead && (rs_mem || rt_mem)));
        hz     = lu || br;
        // Outputs are forced to their released values while Reset is held low.
        stall  = Reset && ((state == BUSY) || hz);
    end

    assign hs.PCWrite      = !stall;
    assign hs.IF_ID_Write  = !stall;
    assign hs.ID_EX_Bubble = stall;
    assign hs.IF_ID_Flush  = Reset && !stall && hs.ID_IsBranch && hs.ID_BranchTaken;
    assign hs.MulBusy      = mul_busy;
    assign hs.StallCycles  = stall_cycles;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= RUN;
            cnt      <= 3'd0;
            mul_busy <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!hz && hs.ID_IsMul) begin
                        state    <= BUSY;
                        cnt      <= 3'(MUL_LAT - 1);
                        mul_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state    <= RUN;
                        mul_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    mul_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            stall_cycles <= 16'd0;
        else if (stall && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
    end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized + directed bench for hazard_stall_unit; two instances (MUL_LAT 4 and 2)
// share stimulus and are compared against a cycle-count reference model.
module tb_hazard_stall_unit;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    hazard_stall_unit_if ifa ();
    hazard_stall_unit_if ifb ();

    hazard_stall_unit #(.MUL_LAT(4)) dut_a (.Clk(Clk), .Reset(Reset), .hs(ifa.slave));
    hazard_stall_unit #(.MUL_LAT(2)) dut_b (.Clk(Clk), .Reset(Reset), .hs(ifb.slave));

    typedef struct packed {
        logic [4:0] rs, rt, erd, mrd;
        logic       ut, br, tk, mul, emr, erw, mmr;
    } stim_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: remaining multiply-hold cycles and stalled-cycle tally.
    int lat[2]       = '{4, 2};
    int busy_left[2] = '{0, 0};
    int sc[2]        = '{0, 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hazard(input stim_t s);
        bit m_rs_ex, m_rt_ex, m_rs_mem, m_rt_mem;
        m_rs_ex  = (s.rs == s.erd) && (s.erd != 0);
        m_rt_ex  = s.ut && (s.rt == s.erd) && (s.erd != 0);
        m_rs_mem = (s.rs == s.mrd) && (s.mrd != 0);
        m_rt_mem = s.ut && (s.rt == s.mrd) && (s.mrd != 0);
        if (s.emr && (m_rs_ex || m_rt_ex)) return 1'b1;
        if (s.br && s.erw && (m_rs_ex || m_rt_ex)) return 1'b1;
        if (s.br && s.mmr && (m_rs_mem || m_rt_mem)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input stim_t s);
        ifa.ID_Rs = s.rs;  ifa.ID_Rt = s.rt;  ifa.ID_UsesRt = s.ut;
        ifa.ID_IsBranch = s.br;  ifa.ID_BranchTaken = s.tk;  ifa.ID_IsMul = s.mul;
        ifa.EX_MemRead = s.emr;  ifa.EX_RegWrite = s.erw;  ifa.EX_Rd = s.erd;
        ifa.MEM_MemRead = s.mmr;  ifa.MEM_Rd = s.mrd;
        ifb.ID_Rs = s.rs;  ifb.ID_Rt = s.rt;  ifb.ID_UsesRt = s.ut;
        ifb.ID_IsBranch = s.br;  ifb.ID_BranchTaken = s.tk;  ifb.ID_IsMul = s.mul;
        ifb.EX_MemRead = s.emr;  ifb.EX_RegWrite = s.erw;  ifb.EX_Rd = s.erd;
        ifb.MEM_MemRead = s.mmr;  ifb.MEM_Rd = s.mrd;
    endtask

    // One clock: drive at negedge, check settled outputs, then advance the model at posedge.
    task automatic step(input stim_t s, input logic rst_n);
        bit hz, st;
        bit e_pc[2], e_fl[2], e_mb[2];
        @(negedge Clk);
        drive(s);
        Reset = rst_n;
        #1;
        hz = hazard(s);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                busy_left[i] = 0;
                sc[i] = 0;
            end
            st      = rst_n && ((busy_left[i] > 0) || hz);
            e_pc[i] = !st;
            e_fl[i] = rst_n && !st && s.br && s.tk;
            e_mb[i] = busy_left[i] > 0;
        end
        chk("a.PCWrite",      ifa.PCWrite,      e_pc[0]);
        chk("a.IF_ID_Write",  ifa.IF_ID_Write,  e_pc[0]);
        chk("a.ID_EX_Bubble", ifa.ID_EX_Bubble, !e_pc[0]);
        chk("a.IF_ID_Flush",  ifa.IF_ID_Flush,  e_fl[0]);
        chk("a.MulBusy",      ifa.MulBusy,      e_mb[0]);
        chk("a.StallCycles",  ifa.StallCycles,  sc[0]);
        chk("b.PCWrite",      ifb.PCWrite,      e_pc[1]);
        chk("b.IF_ID_Write",  ifb.IF_ID_Write,  e_pc[1]);
        chk("b.ID_EX_Bubble", ifb.ID_EX_Bubble, !e_pc[1]);
        chk("b.IF_ID_Flush",  ifb.IF_ID_Flush,  e_fl[1]);
        chk("b.MulBusy",      ifb.MulBusy,      e_mb[1]);
        chk("b.StallCycles",  ifb.StallCycles,  sc[1]);
        @(posedge Clk);
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                st = (busy_left[i] > 0) || hz;
                if (st && sc[i] < 65535) sc[i]++;
                if (busy_left[i] > 0) busy_left[i]--;
                else if (!hz && s.mul) busy_left[i] = lat[i] - 1;
            end
        end
    endtask

    stim_t z, s;

    initial begin
        z = '0;
        drive(z);
        // Reset held with arbitrary, hazardous inputs.
        s = z; s.emr = 1; s.erd = 5'd8; s.rs = 5'd8; s.br = 1; s.tk = 1; s.mul = 1;
        repeat (2) step(s, 1'b0);
        repeat (2) step(z, 1'b1);

        // Load-use, then the $zero and unused-rt non-hazards.
        s = z; s.emr = 1; s.erd = 5'd8; s.rs = 5'd8;
        step(s, 1'b1);
        step(z, 1'b1);
        #1 chk("lu_stall_count", ifa.StallCycles, 32'd1);
        s = z; s.emr = 1; s.erd = 5'd0; s.rs = 5'd0;
        step(s, 1'b1);
        s = z; s.emr = 1; s.erd = 5'd8; s.rt = 5'd8; s.ut = 0; s.rs = 5'd3;
        step(s, 1'b1);

        // Branch against a load: EX then MEM, then a taken branch with no hazard.
        s = z; s.br = 1; s.rs = 5'd9; s.emr = 1; s.erw = 1; s.erd = 5'd9;
        step(s, 1'b1);
        s = z; s.br = 1; s.rs = 5'd9; s.mmr = 1; s.mrd = 5'd9;
        step(s, 1'b1);
        s = z; s.br = 1; s.tk = 1; s.rs = 5'd9;
        step(s, 1'b1);
        step(z, 1'b1);
        #1 chk("br_stall_count", ifa.StallCycles, 32'd3);

        // Multiply accept and hold.
        s = z; s.mul = 1;
        step(s, 1'b1);
        repeat (4) step(z, 1'b1);
        #1 chk("mul_stall_count", ifa.StallCycles, 32'd6);

        // Multiply coincident with load-use: hazard first, then acceptance.
        s = z; s.mul = 1; s.emr = 1; s.erd = 5'd4; s.rt = 5'd4; s.ut = 1;
        step(s, 1'b1);
        s = z; s.mul = 1;
        step(s, 1'b1);
        repeat (4) step(z, 1'b1);

        // Reset pulsed in the 2nd BUSY cycle aborts the hold.
        s = z; s.mul = 1;
        step(s, 1'b1);
        step(z, 1'b1);
        step(z, 1'b0);
        repeat (3) step(z, 1'b1);

        // Randomized traffic with small register numbers to provoke matches.
        for (int n = 0; n < 3000; n++) begin
            s.rs  = 5'($urandom_range(0, 3));
            s.rt  = 5'($urandom_range(0, 3));
            s.erd = 5'($urandom_range(0, 3));
            s.mrd = 5'($urandom_range(0, 3));
            s.ut  = 1'($urandom);
            s.br  = 1'($urandom);
            s.tk  = 1'($urandom);
            s.mul = ($urandom_range(0, 3) == 0);
            s.emr = 1'($urandom);
            s.erw = 1'($urandom);
            s.mmr = 1'($urandom);
            step(s, ($urandom_range(0, 49) != 0));
        end

        // Counter saturation under a continuous load-use hazard.
        step(z, 1'b0);
        s = z; s.emr = 1; s.erd = 5'd8; s.rs = 5'd8;
        repeat (65540) step(s, 1'b1);
        #1 chk("sat_a", ifa.StallCycles, 32'hFFFF);
        chk("sat_b", ifb.StallCycles, 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
